// File: rtl/fetch_stage_if.sv
// IF-side bundle: IF->ID handshake, ID->IF redirect bus and the instruction SRAM port.
// master = fetch stage, slave = ID stage plus SRAM (the environment).
interface fetch_stage_if;
    logic        id_allowin;
    logic [32:0] id_if_bus;
    logic        if_id_valid;
    logic [63:0] if_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    modport master (
        input  id_allowin, id_if_bus, inst_sram_rdata,
        output if_id_valid, if_id_bus, inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
    );

    modport slave (
        output id_allowin, id_if_bus, inst_sram_rdata,
        input  if_id_valid, if_id_bus, inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
    );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues SRAM reads at nextpc, presents {pc, inst} to ID.
// Latency: request in cycle t, instruction offered to ID in t+1; one instruction per cycle unstalled.
// Backpressure: id_allowin low holds IF and parks the fetched word in a one-entry buffer; a branch overrides.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic          clk,
    input  logic          resetn,
    fetch_stage_if.master bus
);
    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    localparam logic [31:0] PC_INIT = RESET_PC - 32'd4;

    br_bus_t     br;
    if_id_t      out_bus;
    logic        pre_valid;
    logic        if_valid;
    logic        buf_valid;
    logic        fresh;
    logic [31:0] if_pc;
    logic [31:0] inst_buf;
    logic [31:0] nextpc;
    logic        if_ready_go;
    logic        if_allowin;
    logic        fetch_req;
    logic        capture;

    assign br = bus.id_if_bus;

    always_comb begin
        nextpc      = if_pc + 32'd4;
        if_ready_go = 1'b1;
        if (br.taken) begin
            nextpc = br.target;
        end
        // A taken branch always frees IF: the current instruction is being killed.
        if_allowin = ~if_valid | (bus.id_allowin & if_ready_go) | br.taken;
        fetch_req  = pre_valid & if_allowin;
        // Park the word only on the cycle SRAM data is live; the SRAM does not hold it afterwards.
        capture    = fresh & if_valid & ~br.taken & ~bus.id_allowin & ~buf_valid;
    end

    assign out_bus.pc   = if_pc;
    assign out_bus.inst = buf_valid ? inst_buf : bus.inst_sram_rdata;

    assign bus.if_id_valid     = if_valid & ~br.taken;
    assign bus.if_id_bus       = out_bus;
    assign bus.inst_sram_en    = fetch_req;
    assign bus.inst_sram_we    = 4'b0;
    assign bus.inst_sram_addr  = nextpc;
    assign bus.inst_sram_wdata = 32'b0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pre_valid <= 1'b0;
            if_valid  <= 1'b0;
            buf_valid <= 1'b0;
            fresh     <= 1'b0;
            if_pc     <= PC_INIT;
            inst_buf  <= 32'b0;
        end else begin
            pre_valid <= 1'b1;
            if (fetch_req) begin
                if_valid  <= 1'b1;
                if_pc     <= nextpc;
                buf_valid <= 1'b0;
                fresh     <= 1'b1;
            end else begin
                fresh <= 1'b0;
                if (br.taken) begin
                    buf_valid <= 1'b0;
                end else if (capture) begin
                    inst_buf  <= bus.inst_sram_rdata;
                    buf_valid <= 1'b1;
                end
            end
        end
    end
endmodule
